// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_e;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned STABLE_CYCLES_DEF = 16;

endpackage

// File: rtl/debounce_fsm_sync.sv
// Multi-flop synchronizer for the raw switch level.
module sync_ff #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[DEPTH-2:0], d};
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/debounce_fsm.sv
// Switch debouncer: synchronizer, stability counter FSM,
// registered level and edge pulses.
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(STABLE_CYCLES - 1);

  logic            s;
  db_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            level_q;
  logic            rise_q;
  logic            fall_q;

  sync_ff #(
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sw),
    .q    (s)
  );

  // Counter only decrements while nonzero, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        ZERO: begin
          if (s) begin
            state_q <= WAIT1;
            cnt_q   <= LOAD;
          end
        end
        WAIT1: begin
          if (!s) begin
            state_q <= ZERO;
          end else if (cnt_q == '0) begin
            state_q <= ONE;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ONE: begin
          if (!s) begin
            state_q <= WAIT0;
            cnt_q   <= LOAD;
          end
        end
        WAIT0: begin
          if (s) begin
            state_q <= ONE;
          end else if (cnt_q == '0) begin
            state_q <= ZERO;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ZERO;
      endcase
    end
  end

  assign db_level = level_q;
  assign db_rise  = rise_q;
  assign db_fall  = fall_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Randomized and directed bench for debounce_fsm against a run-length model.
module tb_debounce_fsm;

  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int LAT    = SYNC + STABLE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw = 1'b0;
  logic db_level, db_rise, db_fall;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: delay line for the synchronizer, then a run counter of
  // consecutive samples that disagree with the accepted level.
  bit dl[$];
  bit m_level;
  bit m_rise;
  bit m_fall;
  int run;

  always #15 clk = ~clk;

  debounce_fsm #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .db_level(db_level),
    .db_rise (db_rise),
    .db_fall (db_fall)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit v);
    bit s;
    if (r) begin
      dl.delete();
      for (int i = 0; i < SYNC; i++) dl.push_back(1'b0);
      m_level = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      run     = 0;
    end else begin
      s = dl[SYNC-1];
      dl.push_front(v);
      void'(dl.pop_back());
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_level) run++;
      else run = 0;
      if (run == STABLE + 1) begin
        m_level = ~m_level;
        m_rise  = m_level;
        m_fall  = ~m_level;
        run     = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit v);
    reset = r;
    sw    = v;
    @(posedge clk);
    model_edge(r, v);
    #1;
    chk("level", int'(db_level), int'(m_level));
    chk("rise",  int'(db_rise),  int'(m_rise));
    chk("fall",  int'(db_fall),  int'(m_fall));
  endtask

  // Hold sw at v for n cycles; report edge index of first level
  // change (-1 if none) and pulse counts.
  task automatic hold(input bit v, input int n, output int lat,
                      output int nr, output int nf);
    bit start;
    start = db_level;
    lat = -1;
    nr  = 0;
    nf  = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, v);
      if (db_rise) nr++;
      if (db_fall) nf++;
      if (lat < 0 && db_level != start) lat = i;
    end
  endtask

  initial begin
    int lat, nr, nf, tr, tf, len;
    bit v;

    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("rst_level", int'(db_level), 0);
    chk("rst_rise",  int'(db_rise), 0);
    chk("rst_fall",  int'(db_fall), 0);

    hold(1'b0, 50, lat, nr, nf);
    chk("idle_lat", lat, -1);
    chk("idle_pulses", nr + nf, 0);

    hold(1'b1, 40, lat, nr, nf);
    chk("rise_lat", lat, LAT);
    chk("rise_cnt", nr, 1);
    chk("rise_nofall", nf, 0);

    hold(1'b0, 40, lat, nr, nf);
    chk("fall_lat", lat, LAT);
    chk("fall_cnt", nf, 1);
    chk("fall_norise", nr, 0);

    tr = 0;
    tf = 0;
    for (int k = 0; k < 10; k++) begin
      hold((k % 2) == 0, 3, lat, nr, nf);
      tr += nr;
      tf += nf;
    end
    chk("bounce_rise", tr, 0);
    chk("bounce_fall", tf, 0);
    hold(1'b1, 40, lat, nr, nf);
    chk("settle_lat", lat, LAT);
    chk("settle_rise", nr, 1);

    hold(1'b0, 40, lat, nr, nf);
    hold(1'b1, 15, lat, nr, nf);
    tr = nr;
    tf = nf;
    hold(1'b0, 30, lat, nr, nf);
    chk("glitch_pulses", tr + tf + nr + nf, 0);
    chk("glitch_level", int'(db_level), 0);

    hold(1'b1, 10, lat, nr, nf);
    tr = nr;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      if (db_rise) tr++;
    end
    chk("rstwait_rise", tr, 0);
    chk("rstwait_level", int'(db_level), 0);
    hold(1'b1, 40, lat, nr, nf);
    chk("rstrel_lat", lat, LAT);
    chk("rstrel_rise", nr, 1);

    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 19) == 0) begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(0, 1)));
      end
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 40)
                                        : $urandom_range(1, 20);
      hold(v, len, lat, nr, nf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_fsm.md
DEBOUNCE_FSM -- requirements
Module: debounce_fsm

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on sw (legal range 2..4).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 16, giving the number of consecutive cycles the synchronized input must hold a new value before it is accepted (legal range 2..2^20).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port sw, input, 1 bit: raw asynchronous button or switch level.
REQ-006 The block SHALL have port db_level, output, 1 bit: debounced level; it drives the level input of edge_detect_gate.
REQ-007 The block SHALL have port db_rise, output, 1 bit: one-cycle pulse when db_level goes 0->1.
REQ-008 The block SHALL have port db_fall, output, 1 bit: one-cycle pulse when db_level goes 1->0.

Function
REQ-009 sw SHALL pass through a SYNC_STAGES-deep flop chain; the last stage output (s) is the only form of sw used by the FSM.
REQ-010 The FSM SHALL have exactly four states: ZERO, WAIT1, ONE, WAIT0.
REQ-011 ZERO: if s=1, go to WAIT1 and load the counter with STABLE_CYCLES-1; otherwise stay in ZERO.
REQ-012 WAIT1: if s=0, return to ZERO (abort, no pulse); else if counter=0, go to ONE; else decrement the counter.
REQ-013 ONE: if s=0, go to WAIT0 and load the counter with STABLE_CYCLES-1; otherwise stay in ONE.
REQ-014 WAIT0: if s=1, return to ONE (abort, no pulse); else if counter=0, go to ZERO; else decrement the counter.
REQ-015 db_level SHALL be a registered output: 1 in states ONE and WAIT0, 0 in states ZERO and WAIT1.
REQ-016 db_rise SHALL be registered and high for exactly the one cycle following the WAIT1->ONE transition edge; db_fall SHALL behave the same for the WAIT0->ZERO transition.
REQ-017 db_rise and db_fall SHALL never be high in the same cycle, and each SHALL coincide with the first cycle of the new db_level value.
REQ-018 If sw is held at a new value, db_level SHALL change exactly SYNC_STAGES+STABLE_CYCLES rising edges after the first edge that samples the new sw value.
REQ-019 Any sw excursion shorter than STABLE_CYCLES cycles (after synchronization) SHALL produce no change on db_level, db_rise or db_fall.
REQ-020 The counter width SHALL be $clog2(STABLE_CYCLES); the counter SHALL never wrap, because it is only decremented while nonzero.
REQ-021 An abort (REQ-012/REQ-014) and a reload in the same cycle SHALL NOT occur; a reversal during a WAIT state always returns to the prior stable state first.

Reset
REQ-022 While reset=1 at a clk edge, the block SHALL clear all synchronizer flops to 0, set state to ZERO and counter to 0, and drive db_level=0, db_rise=0 and db_fall=0.
REQ-023 Reset asserted mid-WAIT SHALL discard the pending transition, with no pulse on db_rise or db_fall.
REQ-024 If sw=1 when reset deasserts, the block SHALL treat it as a new rising input and apply REQ-018, including a db_rise pulse.

Structure
REQ-025 A shared package debounce_pkg SHALL hold the state enum (ZERO, WAIT1, ONE, WAIT0) and the default constants for SYNC_STAGES and STABLE_CYCLES.
REQ-026 The synchronizer SHALL be a separate sub-module sync_ff, parameterized by depth, with ports clk, reset, d and q.
REQ-027 The FSM, counter and output registers SHALL reside in debounce_fsm; there SHALL be no combinational path from sw to any output.

Verification (SYNC_STAGES=2, STABLE_CYCLES=16, 33 MHz clk)
REQ-028 Reset for 10 cycles with sw=0, then release -> db_level=0, db_rise=0 and db_fall=0 for 50 cycles.
REQ-029 sw 0->1 held for 40 cycles -> db_level rises exactly 18 edges after the first edge sampling sw=1, with a single db_rise pulse in that cycle.
REQ-030 sw 1->0 held -> db_level falls 18 edges later, with a single db_fall pulse.
REQ-031 Bounce: sw toggles every 3 cycles for 30 cycles, then settles at 1 -> no db_rise until 18 edges after the final settle, then exactly one db_rise.
REQ-032 Glitch: sw=1 for 15 cycles then 0 -> db_level stays 0 and no pulses occur.
REQ-033 Reset asserted 8 cycles into WAIT1 -> state returns to ZERO and no db_rise occurs; with sw still 1, db_rise occurs 18 edges after reset release.
